mul_seq: RTL
============

MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: operand width; the adder ports are WIDTH bits and the product is 2*WIDTH bits.
REQ-002 The block SHALL have ports clk, input, 1, sole clock, all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 The block SHALL have ports req_valid, input, 1 and req_ready, output, 1: request handshake.
REQ-005 The block SHALL have ports req_mcand, input, WIDTH and req_mplier, input, WIDTH: unsigned multiplicand and multiplier.
REQ-006 The block SHALL have ports rsp_valid, output, 1 and rsp_ready, input, 1: response handshake.
REQ-007 The block SHALL have port rsp_prod, output, 2*WIDTH: unsigned product.
REQ-008 The block SHALL have port flush, input, 1: synchronous abort.
REQ-009 The block SHALL have port busy, output, 1: high in BUSY.
REQ-010 The block SHALL have ports add_a, output, WIDTH; add_b, output, WIDTH; add_cin, output, 1: drive the external ripple-carry adder.
REQ-011 The block SHALL have ports add_s, input, WIDTH and add_cout, input, 1: adder sum and carry-out, combinational from add_a/add_b/add_cin.

Function
REQ-012 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-013 req_ready SHALL equal (state==IDLE) and SHALL NOT depend on req_valid.
REQ-014 The block SHALL accept a request on a rising edge with req_valid&&req_ready, load mcand register M, P_hi=0, P_lo=req_mplier, count=0, and go to BUSY.
REQ-015 In BUSY, add_a SHALL be P_hi, add_b SHALL be (P_lo[0] ? M : 0), and add_cin SHALL be 0; outside BUSY all three SHALL be 0.
REQ-016 Each BUSY cycle SHALL set {P_hi,P_lo} <= {add_cout, add_s, P_lo[WIDTH-1:1]} and increment count.
REQ-017 The FSM SHALL leave BUSY for DONE on the edge completing iteration count==WIDTH-1, so rsp_valid rises WIDTH cycles after the accept edge (32 for default).
REQ-018 rsp_valid SHALL equal (state==DONE), and rsp_prod SHALL equal {P_hi,P_lo} and stay stable while rsp_valid is high.
REQ-019 The FSM SHALL go DONE->IDLE on rsp_valid&&rsp_ready; while rsp_ready is low, DONE SHALL be held indefinitely.
REQ-020 A new request SHALL NOT be accepted in the same cycle the response completes; the earliest accept is the next cycle.
REQ-021 flush=1 SHALL force IDLE on the next edge from any state and discard the result; flush takes priority over accept and response.
REQ-022 req_valid asserted in BUSY or DONE SHALL have no effect.
REQ-023 The count register SHALL be ceil(log2(WIDTH)) bits and SHALL NOT wrap within an operation.

Reset
REQ-024 While rst_n=0, state SHALL be IDLE, and M, P_hi, P_lo and count SHALL be 0.
REQ-025 During reset, req_ready SHALL be 1, rsp_valid SHALL be 0, busy SHALL be 0, rsp_prod SHALL be 0, and add_a, add_b and add_cin SHALL be 0.
REQ-026 Reset asserted mid-operation SHALL abandon the operation immediately, with no response issued.

Configuration
REQ-027 With MUL_ZERO_BYPASS_EN defined, an accept with req_mcand==0 or req_mplier==0 SHALL load P=0 and go directly to DONE, so rsp_valid is high the cycle after the accept edge.
REQ-028 Without MUL_ZERO_BYPASS_EN, every operation SHALL take the full WIDTH iterations per REQ-017.

Verification
REQ-029 The bench SHALL cover: mcand=3, mplier=5 -> rsp_prod=0x000000000000000F, rsp_valid 32 cycles after the accept edge.
REQ-030 The bench SHALL cover: 0xFFFFFFFF*0xFFFFFFFF -> rsp_prod=0xFFFFFFFE00000001, exercising add_cout each iteration.
REQ-031 The bench SHALL cover: 0x12345678*0x9ABCDEF0 with rsp_ready low for 10 cycles -> rsp_valid held, rsp_prod stable at 0x0B00EA4E242D2080, req_ready=0, IDLE one cycle after rsp_ready rises.
REQ-032 The bench SHALL cover: flush at iteration 10 -> IDLE next cycle with no rsp_valid pulse; a following 7*6 request -> rsp_prod=42.
REQ-033 The bench SHALL cover: rst_n pulsed low at iteration 20 -> all outputs at reset values immediately and req_ready=1 after release.
REQ-034 The bench SHALL cover: mcand=0, mplier=0x1234 -> rsp_prod=0, latency 1 cycle with MUL_ZERO_BYPASS_EN defined and 32 cycles without it.

Source files
------------

// File: rtl/mul_seq.sv
// Shift-add unsigned multiplier on an external adder; WIDTH cycles accept->rsp_valid (1 with MUL_ZERO_BYPASS_EN, zero operand).
// Backpressure: DONE holds the product until rsp_ready; req_ready only in IDLE; flush aborts to IDLE.
module mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WIDTH-1:0]   req_mcand,
    input  logic [WIDTH-1:0]   req_mplier,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*WIDTH-1:0] rsp_prod,
    input  logic               flush,
    output logic               busy,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    output logic               add_cin,
    input  logic [WIDTH-1:0]   add_s,
    input  logic               add_cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH-1:0] p_hi;
    logic [WIDTH-1:0] p_lo;
    logic [CW-1:0]    count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            m_reg <= '0;
            p_hi  <= '0;
            p_lo  <= '0;
            count <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        m_reg <= req_mcand;
                        p_hi  <= '0;
                        p_lo  <= req_mplier;
                        count <= '0;
                        state <= BUSY;
`ifdef MUL_ZERO_BYPASS_EN
                        if ((req_mcand == '0) || (req_mplier == '0)) begin
                            p_lo  <= '0;
                            state <= DONE;
                        end
`endif
                    end
                end
                BUSY: begin
                    // Carry-out becomes the new top bit as the partial product shifts right.
                    {p_hi, p_lo} <= {add_cout, add_s, p_lo[WIDTH-1:1]};
                    if (count == CW'(WIDTH - 1)) begin
                        state <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == DONE);
    assign busy      = (state == BUSY);
    assign rsp_prod  = {p_hi, p_lo};
    assign add_a     = busy ? p_hi : '0;
    assign add_b     = (busy && p_lo[0]) ? m_reg : '0;
    assign add_cin   = 1'b0;

endmodule
